// File: rtl/aes128_encryptor.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Optional debug outputs (dbg_state, dbg_round) are enabled by defining AES128_ENC_ROUND_OUT_EN.
module aes128_encryptor (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic [127:0] cipher,
    output logic         busy,
    output logic         done
`ifdef AES128_ENC_ROUND_OUT_EN
    ,
    output logic [127:0] dbg_state,
    output logic [3:0]   dbg_round
`endif
);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {b, 3'b000};
        return SBOX[11'd2047 - idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column packed with row 0 in bits [31:24].
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [127:0] state_q;
    logic [127:0] rkey_q;
    logic [3:0]   rnd_q;

    logic [127:0] sub_st, shift_st, mix_st, next_st;
    logic [127:0] rkey_d;
    logic [31:0]  rot_w, sub_w, w0, w1, w2, w3;

    // Byte i of the state sits at [127-8*i -: 8]; row = i % 4, column = i / 4.
    always_comb begin
        sub_st   = '0;
        shift_st = '0;
        mix_st   = '0;
        for (int i = 0; i < 16; i++) begin
            sub_st[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_st[127-8*(r+4*c) -: 8] = sub_st[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix_st[127-32*c -: 32] = mix_col(shift_st[127-32*c -: 32]);
        end
    end

    always_comb begin
        rot_w  = {rkey_q[23:0], rkey_q[31:24]};
        sub_w  = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
        w0     = rkey_q[127:96] ^ sub_w ^ {rcon(rnd_q), 24'h0};
        w1     = rkey_q[95:64] ^ w0;
        w2     = rkey_q[63:32] ^ w1;
        w3     = rkey_q[31:0] ^ w2;
        rkey_d = {w0, w1, w2, w3};
    end

    // The final round omits MixColumns.
    assign next_st = ((rnd_q == 4'd10) ? shift_st : mix_st) ^ rkey_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            rkey_q  <= '0;
            rnd_q   <= '0;
            cipher  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                state_q <= in ^ key;
                rkey_q  <= key;
                rnd_q   <= 4'd1;
                busy    <= 1'b1;
            end else if (busy) begin
                state_q <= next_st;
                rkey_q  <= rkey_d;
                if (rnd_q == 4'd10) begin
                    cipher <= next_st;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    rnd_q  <= 4'd0;
                end else begin
                    rnd_q <= rnd_q + 4'd1;
                end
            end
        end
    end

`ifdef AES128_ENC_ROUND_OUT_EN
    assign dbg_state = state_q;
    assign dbg_round = rnd_q;
`endif

endmodule

// File: tb/tb_aes128_encryptor.sv
// Self-checking bench for aes128_encryptor against a byte-matrix AES-128 reference model.
module tb_aes128_encryptor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] in_v = '0;
    logic [127:0] key_v = '0;
    logic [127:0] cipher;
    logic         busy;
    logic         done;
`ifdef AES128_ENC_ROUND_OUT_EN
    logic [127:0] dbg_state;
    logic [3:0]   dbg_round;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] sbox_t [256];

    aes128_encryptor dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in     (in_v),
        .key    (key_v),
        .cipher (cipher),
        .busy   (busy),
        .done   (done)
`ifdef AES128_ENC_ROUND_OUT_EN
        ,
        .dbg_state (dbg_state),
        .dbg_round (dbg_round)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = p[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_t[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rnd < 10)
                        s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^
                                  t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[127-8*(r+4*c) -: 8] = s[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Leaves the bench at the falling edge right after the accepting edge.
    task automatic pulse_start(input logic [127:0] p, input logic [127:0] k);
        @(negedge clk);
        in_v  = p;
        key_v = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        in_v  = rand128();
        key_v = rand128();
        repeat (2) @(negedge clk);
        checks++; if (cipher !== 128'h0) begin failures++; $display("FAIL reset_cipher got=%h exp=0", cipher); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef AES128_ENC_ROUND_OUT_EN
        checks++; if (dbg_round !== 4'd0 || dbg_state !== 128'h0) begin
            failures++; $display("FAIL reset_dbg got=%0d/%h exp=0/0", dbg_round, dbg_state);
        end
`endif
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_ignored got=%b exp=0", busy); end
    endtask

    task automatic test_kat();
        logic [127:0] pt [3];
        logic [127:0] kt [3];
        logic [127:0] ct [3];
        int n;
        pt[0] = 128'h3243f6a8885a308d313198a2e0370734;
        kt[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ct[0] = 128'h3925841d02dc09fbdc118597196a0b32;
        pt[1] = 128'h00112233445566778899aabbccddeeff;
        kt[1] = 128'h000102030405060708090a0b0c0d0e0f;
        ct[1] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        pt[2] = 128'h0;
        kt[2] = 128'h0;
        ct[2] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        for (int i = 0; i < 3; i++) begin
            pulse_start(pt[i], kt[i]);
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL kat%0d_busy got=%b exp=1", i, busy); end
`ifdef AES128_ENC_ROUND_OUT_EN
            checks++; if (dbg_round !== 4'd1 || dbg_state !== (pt[i] ^ kt[i])) begin
                failures++; $display("FAIL kat%0d_dbg got=%0d/%h exp=1/%h", i, dbg_round, dbg_state, pt[i] ^ kt[i]);
            end
`endif
            wait_done(n);
            checks++; if (n !== 10) begin failures++; $display("FAIL kat%0d_latency got=%0d exp=10", i, n); end
            checks++; if (cipher !== ct[i]) begin
                failures++; $display("FAIL kat%0d_cipher got=%h exp=%h", i, cipher, ct[i]);
            end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL kat%0d_done_pulse got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_random();
        logic [127:0] p, k;
        int n;
        for (int i = 0; i < 6; i++) begin
            p = rand128();
            k = rand128();
            pulse_start(p, k);
            in_v  = rand128();
            key_v = rand128();
            wait_done(n);
            checks++; if (n !== 10) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=10", i, n); end
            checks++; if (cipher !== aes_ref(p, k)) begin
                failures++; $display("FAIL rand%0d_cipher got=%h exp=%h", i, cipher, aes_ref(p, k));
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [127:0] p, k, exp;
        int n, extra;
        p   = rand128();
        k   = rand128();
        exp = aes_ref(p, k);
        pulse_start(p, k);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_v  = rand128();
            key_v = rand128();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(n);
        checks++; if (n + 6 !== 10) begin failures++; $display("FAIL busy_latency got=%0d exp=10", n + 6); end
        checks++; if (cipher !== exp) begin failures++; $display("FAIL busy_cipher got=%h exp=%h", cipher, exp); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL busy_extra_done got=%0d exp=0", extra); end
        checks++; if (cipher !== exp) begin failures++; $display("FAIL busy_cipher_held got=%h exp=%h", cipher, exp); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pa, ka, pb, kb, ea, eb;
        int n;
        pa = rand128(); ka = rand128(); ea = aes_ref(pa, ka);
        pb = rand128(); kb = rand128(); eb = aes_ref(pb, kb);
        pulse_start(pa, ka);
        wait_done(n);
        checks++; if (cipher !== ea) begin failures++; $display("FAIL b2b_first got=%h exp=%h", cipher, ea); end
        in_v  = pb;
        key_v = kb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL b2b_accept got=busy%b/done%b exp=busy1/done0", busy, done);
        end
        checks++; if (cipher !== ea) begin failures++; $display("FAIL b2b_held got=%h exp=%h", cipher, ea); end
        wait_done(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL b2b_latency got=%0d exp=10", n); end
        checks++; if (cipher !== eb) begin failures++; $display("FAIL b2b_second got=%h exp=%h", cipher, eb); end
    endtask

    task automatic test_reset_midrun();
        int seen;
        pulse_start(rand128(), rand128());
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (cipher !== 128'h0) begin failures++; $display("FAIL abort_cipher got=%h exp=0", cipher); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_flags got=busy%b/done%b exp=busy0/done0", busy, done);
        end
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    endtask

    initial begin
        init_sbox();
        test_reset();
        test_kat();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
